ysyx_23060184_sram: RTL and testbench

YSYX_23060184_SRAM -- requirements
Module: ysyx_23060184_sram

---
 rtl/ysyx_23060184_sram_pkg.sv | 12 +
 rtl/ysyx_23060184_lfsr16.sv | 16 +
 rtl/ysyx_23060184_sram.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_23060184_sram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_sram_pkg.sv
// Shared response codes, FSM encodings and default placement for the SRAM slave.
package ysyx_23060184_sram_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

endpackage

// File: rtl/ysyx_23060184_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16/14/13/11), seeded with 16'hACE1, advancing every cycle.
module ysyx_23060184_lfsr16 (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] q
);

   logic fb;
   assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 16'hACE1;
      else       q <= {q[14:0], fb};
   end

endmodule

// File: rtl/ysyx_23060184_sram.sv
// AXI-lite style word SRAM slave with independent read and write channels.
// Define YSYX_23060184_SRAM_RAND_DELAY_EN to add a pseudo-random 0..7 cycles to each wait.
module ysyx_23060184_sram
   import ysyx_23060184_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam int          CW   = $clog2(LATENCY + 9);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   logic [31:0] mem [DEPTH_WORDS];

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;

   logic [CW-1:0] lat_load, r_cnt, w_cnt;
   logic [31:0]   ar_addr_q, aw_addr_q, w_data_q;
   logic [3:0]    w_strb_q;
   logic          aw_got, w_got;
   logic          r_load, r_dec, r_sample;
   logic          w_load, w_dec, w_commit, w_clr, aw_hs, w_hs;

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
   logic [15:0] lfsr_q;
   logic        unused_lfsr;

   ysyx_23060184_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[15:3];
   assign lat_load    = CW'(LATENCY) + CW'(lfsr_q[2:0]);
`else
   assign lat_load = CW'(LATENCY);
`endif

   // A zero-cycle wait samples straight from the incoming address during the handshake.
   logic [31:0]   r_addr, r_off, w_off;
   logic [AW-1:0] r_idx, w_idx;
   logic          r_hit, w_hit;

   assign r_addr = (r_state == R_IDLE) ? araddr : ar_addr_q;
   assign r_off  = r_addr - BASE_ADDR;
   assign r_idx  = r_off[2 +: AW];
   assign r_hit  = {1'b0, r_off} < SPAN;

   assign w_off  = aw_addr_q - BASE_ADDR;
   assign w_idx  = w_off[2 +: AW];
   assign w_hit  = {1'b0, w_off} < SPAN;

   assign rvalid = (r_state == R_RESP);
   assign bvalid = (w_state == W_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
      end
   end

   always_comb begin
      r_next   = r_state;
      arready  = 1'b0;
      r_load   = 1'b0;
      r_dec    = 1'b0;
      r_sample = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               if (lat_load == '0) begin
                  r_next   = R_RESP;
                  r_sample = 1'b1;
               end else begin
                  r_next = R_WAIT;
                  r_load = 1'b1;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt <= CW'(1)) begin
               r_next   = R_RESP;
               r_sample = 1'b1;
            end else begin
               r_dec = 1'b1;
            end
         end
         R_RESP: if (rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next   = w_state;
      awready  = 1'b0;
      wready   = 1'b0;
      aw_hs    = 1'b0;
      w_hs     = 1'b0;
      w_load   = 1'b0;
      w_dec    = 1'b0;
      w_commit = 1'b0;
      w_clr    = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !aw_got;
            wready  = !w_got;
            aw_hs   = awvalid && !aw_got;
            w_hs    = wvalid && !w_got;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
               w_next = W_WAIT;
               w_load = 1'b1;
            end
         end
         W_WAIT: begin
            if (w_cnt == '0) begin
               w_next   = W_RESP;
               w_commit = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) begin
               w_next = W_IDLE;
               w_clr  = 1'b1;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         ar_addr_q <= '0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
      end else begin
         if (r_load) begin
            r_cnt     <= lat_load;
            ar_addr_q <= araddr;
         end else if (r_dec) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_sample) begin
            rdata <= r_hit ? mem[r_idx] : '0;
            rresp <= r_hit ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_cnt     <= '0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         bresp     <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= awaddr;
            aw_got    <= 1'b1;
         end
         if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            w_got    <= 1'b1;
         end
         if (w_load)     w_cnt <= lat_load;
         else if (w_dec) w_cnt <= w_cnt - CW'(1);
         if (w_commit)   bresp <= w_hit ? RESP_OKAY : RESP_DECERR;
         if (w_clr) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
      end
   end

   // Storage is never reset; a same-cycle read sees the old word because both use edge semantics.
   always_ff @(posedge clk) begin
      if (w_commit && w_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060184_sram.sv
// Directed bench for the SRAM slave: reset state, read/write paths, ordering, errors, backpressure, reset abort.
module tb_ysyx_23060184_sram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [3:0]  wstrb = '0;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   int n_chk = 0;
   int n_pass = 0;

   ysyx_23060184_sram #(
      .BASE_ADDR   (32'h8000_0000),
      .DEPTH_WORDS (4096),
      .LATENCY     (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, got, exp);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      resp = bvalid ? bresp : 2'bxx;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
      d    = rvalid ? rdata : 32'hxxxx_xxxx;
      resp = rvalid ? rresp : 2'bxx;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat, n, pulses;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_arready", 32'(arready), 1);
      chk("rst_awready", 32'(awready), 1);
      chk("rst_wready",  32'(wready),  1);
      chk("rst_rvalid",  32'(rvalid),  0);
      chk("rst_bvalid",  32'(bvalid),  0);
      chk("rst_rdata",   rdata,        0);
      chk("rst_rresp",   32'(rresp),   0);
      chk("rst_bresp",   32'(bresp),   0);
      reset = 1'b0;

      // read hit with timing
      do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, r);
      chk("w0_bresp", 32'(r), 0);
      @(negedge clk);
      araddr = 32'h8000_0000; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk("rd_arready_busy", 32'(arready), 0);
      chk("rd_rvalid_t1", 32'(rvalid), 0);
      @(negedge clk);
      chk("rd_rvalid_t2", 32'(rvalid), 1);
      chk("rd_rdata", rdata, 32'hDEAD_BEEF);
      chk("rd_rresp", 32'(rresp), 0);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("rd_rvalid_done", 32'(rvalid), 0);
      chk("rd_arready_back", 32'(arready), 1);

      // byte strobes
      do_write(32'h8000_0010, 32'h1122_3344, 4'hF, r);
      do_write(32'h8000_0010, 32'hAABB_CCDD, 4'b0101, r);
      chk("strb_bresp", 32'(r), 0);
      do_read(32'h8000_0010, d, r, lat);
      chk("strb_data", d, 32'h11BB_33DD);
      chk("strb_lat", 32'(lat), 1);
      do_read(32'h8000_0013, d, r, lat);
      chk("lowbits_ignored", d, 32'h11BB_33DD);
      do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, r);
      chk("strb0_bresp", 32'(r), 0);
      do_read(32'h8000_0010, d, r, lat);
      chk("strb0_data", d, 32'h11BB_33DD);

      // W three cycles ahead of AW
      @(negedge clk);
      awaddr = 32'h8000_0020; wdata = 32'h5555_6666; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("ord_wready_lo", 32'(wready), 0);
      chk("ord_awready_hi", 32'(awready), 1);
      repeat (2) @(negedge clk);
      chk("ord_bvalid_early", 32'(bvalid), 0);
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; bready = 1'b1;
      pulses = 0;
      repeat (10) begin
         if (bvalid) pulses++;
         @(negedge clk);
      end
      bready = 1'b0;
      chk("ord_pulses", 32'(pulses), 1);
      do_read(32'h8000_0020, d, r, lat);
      chk("ord_data", d, 32'h5555_6666);

      // out of range
      do_read(32'h7FFF_FFFC, d, r, lat);
      chk("oor_rresp", 32'(r), 3);
      chk("oor_rdata", d, 0);
      do_write(32'h8000_4000, 32'h0BAD_0BAD, 4'hF, r);
      chk("oor_bresp", 32'(r), 3);
      do_read(32'h8000_0000, d, r, lat);
      chk("oor_word0", d, 32'hDEAD_BEEF);

      // read backpressure
      @(negedge clk);
      araddr = 32'h8000_0000; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         chk("bp_rvalid",  32'(rvalid),  1);
         chk("bp_rdata",   rdata,        32'hDEAD_BEEF);
         chk("bp_arready", 32'(arready), 0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("bp_rvalid_drop", 32'(rvalid), 0);

      // concurrent read and write
      @(negedge clk);
      araddr = 32'h8000_0000; arvalid = 1'b1;
      awaddr = 32'h8000_0030; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!(rvalid && bvalid) && n < 50) begin @(negedge clk); n++; end
      chk("cc_both_valid", 32'(rvalid && bvalid), 1);
      chk("cc_rdata", rdata, 32'hDEAD_BEEF);
      chk("cc_bresp", 32'(bresp), 0);
      rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      do_read(32'h8000_0030, d, r, lat);
      chk("cc_wdata", d, 32'hCAFE_F00D);

      // reset while the write waits
      @(negedge clk);
      awaddr = 32'h8000_0010; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rw_arready", 32'(arready), 1);
      chk("rw_awready", 32'(awready), 1);
      chk("rw_wready",  32'(wready),  1);
      pulses = 0;
      repeat (5) begin
         if (bvalid) pulses++;
         @(negedge clk);
      end
      chk("rw_no_bvalid", 32'(pulses), 0);
      do_read(32'h8000_0010, d, r, lat);
      chk("rw_word_kept", d, 32'h11BB_33DD);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
